// File: rtl/aabb_scan_sched.sv
// ---------------------------------------------------------------------------
// aabb_scan_sched
//   Sweeps one ray against a list of boxes held in an external box RAM.
//   Issues one box per cycle into a pipelined AABB slab-test unit, collects
//   the in-order results, and reports the nearest hit: the smallest signed
//   tmin among results with ray_hit=1. On equal tmin the lower index wins.
//
// Packed layouts:
//   Ray         : RAY_W  = 6*WIDTH bits  {origin xyz, direction xyz}
//   AABB        : AABB_W = 6*WIDTH + COLOR_W bits {min xyz, max xyz, colour}
//   AABB_result : {box[AABB_W], ray_hit[1], tmin[WIDTH]}
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ray_valid/ray_ready upstream handshake; ray_in, box_count sampled on it
//   box_rd_en/box_addr  box RAM read port; box_rd_data valid 1 cycle later
//   aabb_start/ray/box  issue port to the AABB unit
//   aabb_result/valid   results from the AABB unit, one per issue, in order
//   res_valid/res_ready downstream handshake for the final result
//   res_hit/tmin/box/idx  nearest-hit result (tmin=MAX when no hit)
//   busy                scheduler not idle
//   err                 sticky: result arrived with none outstanding
// ---------------------------------------------------------------------------
module aabb_scan_sched #(
    parameter int unsigned     WIDTH   = 16,
    parameter int unsigned     Q_BITS  = 8,
    parameter logic [WIDTH-1:0] MAX    = 16'h7FFF,
    parameter int unsigned     ADDR_W  = 6,
    parameter int unsigned     COLOR_W = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ray_valid,
    output logic                          ray_ready,
    input  logic [6*WIDTH-1:0]            ray_in,
    input  logic [ADDR_W:0]               box_count,
    output logic                          box_rd_en,
    output logic [ADDR_W-1:0]             box_addr,
    input  logic [6*WIDTH+COLOR_W-1:0]    box_rd_data,
    output logic                          aabb_start,
    output logic [6*WIDTH-1:0]            aabb_ray,
    output logic [6*WIDTH+COLOR_W-1:0]    aabb_box,
    input  logic [7*WIDTH+COLOR_W:0]      aabb_result,
    input  logic                          aabb_valid,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_hit,
    output logic [WIDTH-1:0]              res_tmin,
    output logic [6*WIDTH+COLOR_W-1:0]    res_box,
    output logic [ADDR_W-1:0]             res_idx,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned RAY_W  = 6 * WIDTH;
    localparam int unsigned AABB_W = 6 * WIDTH + COLOR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    // Fixed-point format sanity; Q_BITS carries no arithmetic here.
    if (Q_BITS > WIDTH) begin : g_qbits_check
        $error("aabb_scan_sched: Q_BITS must not exceed WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_n, r_rd_ptr, r_rcv_cnt;
    logic [RAY_W-1:0]    r_ray;
    logic                r_start;
    logic                r_best_hit;
    logic [WIDTH-1:0]    r_best_tmin;
    logic [AABB_W-1:0]   r_best_box;
    logic [ADDR_W-1:0]   r_best_idx;
    logic                r_err;

    logic [AABB_W-1:0]   w_res_box;
    logic                w_res_hit;
    logic [WIDTH-1:0]    w_res_tmin;
    logic                w_accept, w_rcv_ok, w_update;
    logic [ADDR_W:0]     w_rcv_next;

    assign {w_res_box, w_res_hit, w_res_tmin} = aabb_result;

    assign w_accept = ray_valid && (r_state == IDLE);

    // A result is only collected while a scan is live and still owes results;
    // anything else is flagged as unexpected and dropped.
    assign w_rcv_ok   = aabb_valid && (r_rcv_cnt < r_n) &&
                        (r_state != IDLE) && (r_state != DONE);
    assign w_rcv_next = w_rcv_ok ? (r_rcv_cnt + CNT_ONE) : r_rcv_cnt;
    // Strict less-than keeps the earlier index on a tie.
    assign w_update   = w_rcv_ok && w_res_hit &&
                        (!r_best_hit || ($signed(w_res_tmin) < $signed(r_best_tmin)));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ray_ready = 1'b0;
        box_rd_en = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                ray_ready = 1'b1;
                busy      = 1'b0;
                if (ray_valid) w_next = (box_count != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                box_rd_en = 1'b1;
                if (r_rd_ptr == r_n - CNT_ONE) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_rcv_next == r_n) w_next = DONE;
            end
            DONE: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n         <= '0;
            r_rd_ptr    <= '0;
            r_rcv_cnt   <= '0;
            r_ray       <= '0;
            r_start     <= 1'b0;
            r_best_hit  <= 1'b0;
            r_best_tmin <= '0;
            r_best_box  <= '0;
            r_best_idx  <= '0;
            r_err       <= 1'b0;
        end else begin
            // RAM data lands one cycle after the read, so the start strobe
            // is the read strobe delayed by one.
            r_start <= box_rd_en;
            if (w_accept) begin
                r_ray       <= ray_in;
                r_n         <= box_count;
                r_rd_ptr    <= '0;
                r_rcv_cnt   <= '0;
                r_best_hit  <= 1'b0;
                r_best_tmin <= MAX;
                r_best_box  <= '0;
                r_best_idx  <= '0;
            end else begin
                if (box_rd_en) r_rd_ptr  <= r_rd_ptr + CNT_ONE;
                if (w_rcv_ok)  r_rcv_cnt <= r_rcv_cnt + CNT_ONE;
                if (w_update) begin
                    r_best_hit  <= 1'b1;
                    r_best_tmin <= w_res_tmin;
                    r_best_box  <= w_res_box;
                    r_best_idx  <= r_rcv_cnt[ADDR_W-1:0];
                end
            end
            if (aabb_valid && !w_rcv_ok) r_err <= 1'b1;
        end
    end

    assign box_addr   = r_rd_ptr[ADDR_W-1:0];
    assign aabb_start = r_start;
    assign aabb_ray   = r_ray;
    assign aabb_box   = box_rd_data;
    assign res_valid  = (r_state == DONE);
    assign res_hit    = r_best_hit;
    assign res_tmin   = r_best_tmin;
    assign res_box    = r_best_box;
    assign res_idx    = r_best_idx;
    assign err        = r_err;

endmodule

// File: tb/tb_aabb_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_aabb_scan_sched
//   Drives rays into aabb_scan_sched with a box RAM model and a fixed-latency
//   AABB stand-in whose hit/tmin come from the box colour field
//   (colour[16]=hit, colour[15:0]=tmin). Expected results are pushed into a
//   scoreboard at ray acceptance; a monitor pops and compares on each result
//   handshake.
// ---------------------------------------------------------------------------
module tb_aabb_scan_sched;

    localparam int W     = 16;
    localparam int AW    = 6;
    localparam int CW    = 24;
    localparam int L     = 3;
    localparam int RAY_W = 6 * W;
    localparam int BOX_W = 6 * W + CW;
    localparam int RES_W = BOX_W + 1 + W;
    localparam logic [W-1:0] MAXV = 16'h7FFF;

    logic               clk = 1'b0;
    logic               reset;
    logic               ray_valid, ray_ready;
    logic [RAY_W-1:0]   ray_in;
    logic [AW:0]        box_count;
    logic               box_rd_en;
    logic [AW-1:0]      box_addr;
    logic [BOX_W-1:0]   box_rd_data = '0;
    logic               aabb_start;
    logic [RAY_W-1:0]   aabb_ray;
    logic [BOX_W-1:0]   aabb_box;
    logic [RES_W-1:0]   aabb_result;
    logic               aabb_valid;
    logic               res_valid, res_ready, res_hit;
    logic [W-1:0]       res_tmin;
    logic [BOX_W-1:0]   res_box;
    logic [AW-1:0]      res_idx;
    logic               busy, err;

    aabb_scan_sched #(
        .WIDTH(W), .Q_BITS(8), .MAX(MAXV), .ADDR_W(AW), .COLOR_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_in(ray_in),
        .box_count(box_count),
        .box_rd_en(box_rd_en), .box_addr(box_addr), .box_rd_data(box_rd_data),
        .aabb_start(aabb_start), .aabb_ray(aabb_ray), .aabb_box(aabb_box),
        .aabb_result(aabb_result), .aabb_valid(aabb_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_tmin(res_tmin), .res_box(res_box),
        .res_idx(res_idx), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- box RAM and AABB stand-in ----------------
    logic [BOX_W-1:0] ram [0:63];
    always @(posedge clk) if (box_rd_en) box_rd_data <= ram[box_addr];

    logic [L-1:0]     pv;
    logic [RES_W-1:0] pr [0:L-1];
    logic             inj = 1'b0;
    always @(posedge clk) begin
        if (reset) pv <= '0;
        else       pv <= {pv[L-2:0], aabb_start};
        pr[0] <= {aabb_box, aabb_box[16], aabb_box[15:0]};
        for (int i = 1; i < L; i++) pr[i] <= pr[i-1];
    end
    assign aabb_valid  = pv[L-1] | inj;
    assign aabb_result = pr[L-1];

    function automatic logic [BOX_W-1:0] mk_box(input logic hit, input logic [W-1:0] tmin);
        return {$urandom(), $urandom(), $urandom(), 7'b0, hit, tmin};
    endfunction

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic             hit;
        logic [W-1:0]     tmin;
        logic [AW-1:0]    idx;
        logic [BOX_W-1:0] box;
        int               n;
        int               acc;
        logic [RAY_W-1:0] ray;
    } exp_t;
    exp_t sbq[$];

    // Nearest hit: find the minimum signed tmin over hitting boxes, then the
    // lowest index carrying that tmin.
    function automatic exp_t model(input int n, input logic [RAY_W-1:0] r);
        exp_t e;
        logic found;
        logic signed [W-1:0] mn;
        found = 1'b0; mn = '0;
        e.hit = 1'b0; e.tmin = MAXV; e.idx = '0; e.box = '0;
        e.n = n; e.acc = 0; e.ray = r;
        for (int i = 0; i < n; i++)
            if (ram[i][16] && (!found || $signed(ram[i][15:0]) < mn)) begin
                mn = ram[i][15:0];
                found = 1'b1;
            end
        if (found) begin
            e.hit = 1'b1;
            e.tmin = mn;
            for (int i = n - 1; i >= 0; i--)
                if (ram[i][16] && ram[i][15:0] == mn) begin
                    e.idx = AW'(i);
                    e.box = ram[i];
                end
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    int rd_cnt = 0, rd_first = 0, rd_last = 0, st_cnt = 0, rise = 0;
    bit ray_bad = 1'b0, prev_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_cnt = 0; st_cnt = 0; ray_bad = 1'b0; prev_rv = 1'b0;
        end else begin
            if (box_rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
            end
            if (aabb_start) begin
                st_cnt++;
                if (sbq.size() != 0 && aabb_ray !== sbq[0].ray) ray_bad = 1'b1;
            end
            if (res_valid && !prev_rv) rise = cyc;
            prev_rv = res_valid;
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_hit",  res_hit,  e.hit);
                    chk("res_tmin", res_tmin, e.tmin);
                    chk("res_idx",  res_idx,  e.idx);
                    chk("res_box",  res_box,  e.box);
                    chk("latency",  rise - e.acc + 1, (e.n == 0) ? 1 : e.n + L + 2);
                    chk("rd_count", rd_cnt, e.n);
                    chk("rd_contig", (rd_cnt == 0) ? 0 : rd_last - rd_first + 1, rd_cnt);
                    chk("start_count", st_cnt, e.n);
                    chk("aabb_ray_held", ray_bad, 0);
                end
                rd_cnt = 0; st_cnt = 0; ray_bad = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_ray(input int n, input bit push);
        exp_t e;
        @(posedge clk); #1;
        chk("ray_ready_idle", ray_ready, 1);
        ray_in    = {$urandom(), $urandom(), $urandom()};
        box_count = (AW+1)'(n);
        ray_valid = 1'b1;
        e = model(n, ray_in);
        @(posedge clk); #1;
        ray_valid = 1'b0;
        e.acc = cyc;
        if (push) sbq.push_back(e);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!res_valid && t < 300) begin @(posedge clk); #1; t++; end
        if (!res_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic take_result(input int hold);
        wait_valid();
        repeat (hold) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic fill(input int mode);
        int pct;
        pct = (mode == 0) ? 50 : (mode == 1) ? 15 : 90;
        for (int i = 0; i < 64; i++)
            ram[i] = mk_box($urandom_range(0, 99) < pct,
                            (mode == 2) ? W'($urandom_range(0, 3)) : W'($urandom()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] snap;
        exp_t eb;
        reset = 1'b1; ray_valid = 1'b0; ray_in = '0; box_count = '0; res_ready = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ray_ready", ray_ready, 1);
        chk("rst_box_rd_en", box_rd_en, 0);
        chk("rst_aabb_start", aabb_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_hit", res_hit, 0);
        chk("rst_res_tmin", res_tmin, 0);
        chk("rst_res_box", res_box, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // tmin 5.0, 2.0, miss, 7.0 (Q8.8)
        ram[0] = mk_box(1'b1, 16'h0500);
        ram[1] = mk_box(1'b1, 16'h0200);
        ram[2] = mk_box(1'b0, 16'h0100);
        ram[3] = mk_box(1'b1, 16'h0700);
        send_ray(4, 1); take_result(0);

        for (int i = 0; i < 3; i++) ram[i] = mk_box(1'b0, 16'h0000);
        send_ray(3, 1); take_result(1);

        ram[0] = mk_box(1'b0, 16'h0000);
        ram[1] = mk_box(1'b1, 16'h0400);
        ram[2] = mk_box(1'b1, 16'h0400);
        send_ray(3, 1); take_result(0);

        send_ray(0, 1); take_result(0);

        // Result held under backpressure while a new ray waits upstream.
        fill(0);
        send_ray(2, 1);
        wait_valid();
        snap = {res_hit, res_tmin, res_idx, res_box};
        ray_in = {$urandom(), $urandom(), $urandom()};
        box_count = '0;
        ray_valid = 1'b1;
        eb = model(0, ray_in);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("hold_stable", {res_hit, res_tmin, res_idx, res_box}, snap);
            chk("hold_ray_ready", {ray_ready, res_valid}, 2'b01);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("idle_after_take", {busy, ray_ready}, 2'b01);
        @(posedge clk); #1;
        ray_valid = 1'b0;
        eb.acc = cyc;
        sbq.push_back(eb);
        take_result(0);

        // Full address range, only the last box hits.
        for (int i = 0; i < 64; i++) ram[i] = mk_box(1'b0, W'($urandom()));
        ram[63] = mk_box(1'b1, 16'hF000);
        send_ray(64, 1); take_result(0);
        fill(0);
        send_ray(64, 1); take_result(2);

        for (int k = 0; k < 20; k++) begin
            int n;
            fill($urandom_range(0, 2));
            n = $urandom_range(0, 64);
            send_ray(n, 1);
            take_result($urandom_range(0, 3));
        end
        chk("err_clean", err, 0);

        // Reset during ISSUE with rd_ptr=2, then a stray result.
        fill(0);
        send_ray(8, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_scan_addr", {box_rd_en, box_addr}, {1'b1, 6'd2});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_idle", {ray_ready, res_valid, busy, box_rd_en}, 4'b1000);
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_no_err", err, 0);
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        chk("stray_err", err, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("err_sticky", err, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("err_cleared", err, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
